// File: rtl/sme_failfunc_scheduler_pkg.sv
// Shared widths, timing constants and FSM encoding for the failure-function scheduler.
//   ByteW      : bits per pattern character
//   MaxPattern : pattern length in bytes
//   MaxPatAdd  : width of a pattern index / failure-function entry
//   FfTimeout  : RUN cycles allowed before the engine is declared hung
package sme_failfunc_scheduler_pkg;

  localparam int unsigned ByteW      = 8;
  localparam int unsigned MaxPattern = 32;
  localparam int unsigned MaxPatAdd  = 5;
  localparam int unsigned FfTimeout  = 40;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRelease,
    StResp
  } sched_state_e;

endpackage

// File: rtl/sme_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after rr_ptr, wrapping.
//   req       : pending request vector
//   rr_ptr    : index that has highest priority this cycle
//   grant     : one-hot grant (all zero when nothing is pending)
//   grant_idx : binary index of the granted requester
//   any       : at least one request pending
module sme_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  always_comb begin
    int unsigned k;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(rr_ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = k[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sme_failfunc_scheduler.sv
// Shares one DP_FailFunc engine among NUM_REQ pattern requesters.
// A round-robin pick latches the winner's pattern, drives the engine handshake
// (i_valid held until o_valid, then one idle cycle), and returns the failure-function
// vector tagged with the requester ID, or an all-zero vector with res_error on timeout.
//   clk, reset        : clock, asynchronous active-low reset
//   req_valid/ack     : per-requester level request, one-cycle one-hot accept pulse
//   req_pattern       : flattened patterns, slot k at [k*MAX_PATTERN*8 +: MAX_PATTERN*8]
//   req_last_idx      : flattened last pattern index per requester
//   res_*             : result handshake (valid/ready), owner id, vector, timeout flag
//   ff_*              : engine-side handshake and registered pattern/last index
module sme_failfunc_scheduler
  import sme_failfunc_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned MAX_PATTERN = MaxPattern,
  parameter int unsigned PAT_ADDR_W  = MaxPatAdd,
  parameter int unsigned TIMEOUT     = FfTimeout
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*MAX_PATTERN*8-1:0]  req_pattern,
  input  logic [NUM_REQ*PAT_ADDR_W-1:0]     req_last_idx,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [ID_W-1:0]                   res_id,
  output logic [PAT_ADDR_W*MAX_PATTERN-1:0] res_fail_func,
  output logic                              res_error,
  output logic                              ff_i_valid,
  output logic [MAX_PATTERN*8-1:0]          ff_pattern,
  output logic [PAT_ADDR_W-1:0]             ff_last_pat_idx,
  input  logic [PAT_ADDR_W*MAX_PATTERN-1:0] ff_o_fail_func,
  input  logic                              ff_o_valid
);

  localparam int unsigned PatW = MAX_PATTERN * ByteW;
  localparam int unsigned FfW  = PAT_ADDR_W * MAX_PATTERN;
  localparam int unsigned CntW = $clog2(TIMEOUT);

  sched_state_e         state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic                 res_valid_q, res_valid_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic [FfW-1:0]       res_ff_q, res_ff_d;
  logic                 res_error_q, res_error_d;
  logic                 ff_i_valid_q, ff_i_valid_d;
  logic [PatW-1:0]      ff_pattern_q, ff_pattern_d;
  logic [PAT_ADDR_W-1:0] ff_last_q, ff_last_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_any;

  sme_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    req_ack_d    = '0;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_ff_d     = res_ff_q;
    res_error_d  = res_error_q;
    ff_i_valid_d = ff_i_valid_q;
    ff_pattern_d = ff_pattern_q;
    ff_last_d    = ff_last_q;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          ff_pattern_d = req_pattern[arb_idx*PatW +: PatW];
          ff_last_d    = req_last_idx[arb_idx*PAT_ADDR_W +: PAT_ADDR_W];
          res_id_d     = arb_idx;
          req_ack_d    = arb_grant;
          ff_i_valid_d = 1'b1;
          // Explicit wrap so non-power-of-two NUM_REQ also works.
          rr_ptr_d     = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + ID_W'(1);
          cnt_d        = '0;
          state_d      = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        // A result arriving on the last allowed cycle still counts as success.
        if (ff_o_valid) begin
          res_ff_d     = ff_o_fail_func;
          res_error_d  = 1'b0;
          ff_i_valid_d = 1'b0;
          state_d      = StRelease;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          res_ff_d     = '0;
          res_error_d  = 1'b1;
          ff_i_valid_d = 1'b0;
          state_d      = StRelease;
        end
      end
      StRelease: begin
        // i_valid is already low here, giving the engine its cycle to drop back to idle.
        res_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_error_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      req_ack_q    <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_ff_q     <= '0;
      res_error_q  <= 1'b0;
      ff_i_valid_q <= 1'b0;
      ff_pattern_q <= '0;
      ff_last_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      req_ack_q    <= req_ack_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_ff_q     <= res_ff_d;
      res_error_q  <= res_error_d;
      ff_i_valid_q <= ff_i_valid_d;
      ff_pattern_q <= ff_pattern_d;
      ff_last_q    <= ff_last_d;
    end
  end

  assign req_ack         = req_ack_q;
  assign res_valid       = res_valid_q;
  assign res_id          = res_id_q;
  assign res_fail_func   = res_ff_q;
  assign res_error       = res_error_q;
  assign ff_i_valid      = ff_i_valid_q;
  assign ff_pattern      = ff_pattern_q;
  assign ff_last_pat_idx = ff_last_q;

endmodule
